// File: rtl/pll_lock_rst_seq.sv
`timescale 1ns/1ps
// ============================================================================
// pll_lock_rst_seq
// ----------------------------------------------------------------------------
// Lock-qualified reset sequencer for the system PLL. Runs on the free-running
// reference clock so it keeps working while the PLL is unlocked.
//   - pulses pll_rst after reset and after every lock timeout
//   - requires LOCK_STABLE_CYCLES consecutive synchronised-locked cycles
//   - releases rst_out_n[0..NUM_STAGES-1] one at a time, STAGE_GAP apart,
//     then raises ready STAGE_GAP cycles after the last release
//   - any loss of lock in RELEASE/RUN drops every domain reset at once and
//     returns to WAIT_LOCK without re-pulsing the PLL
//
// Optional feature macro: LOCK_LOSS_CNT_EN
//   defined   : saturating lock-loss event counter with synchronous clear
//   undefined : no counter logic, lock_loss_cnt tied to 0, clr_cnt ignored
//
// Ports
//   clk           in   reference clock (same net as PLL refclk)
//   rst_n         in   synchronous active-low reset
//   pll_locked    in   PLL locked flag, asynchronous to clk
//   clr_cnt       in   synchronous clear of lock_loss_cnt
//   pll_rst       out  PLL reset, active high, straight from a flop
//   rst_out_n     out  per-domain resets, active low, bit 0 released first
//   ready         out  all stages released and lock stable
//   lock_loss_cnt out  saturating count of lock-loss events
// ============================================================================
module pll_lock_rst_seq #(
    parameter int PLL_RST_CYCLES     = 32,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int STAGE_GAP          = 16,
    parameter int NUM_STAGES         = 3,
    parameter int CNT_W              = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  clr_cnt,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] rst_out_n,
    output logic                  ready,
    output logic [CNT_W-1:0]      lock_loss_cnt
);

    localparam int PR_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int ST_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam int GP_W = $clog2(STAGE_GAP + 1);
    localparam logic [NUM_STAGES-1:0] STAGE0 = NUM_STAGES'(1);

    typedef enum logic [1:0] {
        ST_PLLRST    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                state_r, state_nxt_s;
    logic [PR_W-1:0]       prc_r, prc_nxt_s;
    logic [ST_W-1:0]       stb_r, stb_nxt_s;
    logic [TO_W-1:0]       tmo_r, tmo_nxt_s;
    logic [GP_W-1:0]       gap_r, gap_nxt_s;
    logic                  pll_rst_r, pll_rst_nxt_s;
    logic [NUM_STAGES-1:0] rst_out_n_r, rst_out_n_nxt_s;
    logic                  ready_r, ready_nxt_s;
    logic                  sync_q1_r, lk_sync_r;
    logic                  lk_s;
    logic                  loss_evt_s;

    assign lk_s = lk_sync_r;

    // Two-flop synchroniser for the asynchronous PLL locked flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1_r <= 1'b0;
            lk_sync_r <= 1'b0;
        end else begin
            sync_q1_r <= pll_locked;
            lk_sync_r <= sync_q1_r;
        end
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        prc_nxt_s       = prc_r;
        stb_nxt_s       = stb_r;
        tmo_nxt_s       = tmo_r;
        gap_nxt_s       = gap_r;
        pll_rst_nxt_s   = pll_rst_r;
        rst_out_n_nxt_s = rst_out_n_r;
        ready_nxt_s     = ready_r;
        loss_evt_s      = 1'b0;

        case (state_r)
            ST_PLLRST: begin
                if (prc_r == PR_W'(PLL_RST_CYCLES)) begin
                    state_nxt_s   = ST_WAIT_LOCK;
                    pll_rst_nxt_s = 1'b0;
                    stb_nxt_s     = '0;
                    tmo_nxt_s     = '0;
                end else begin
                    prc_nxt_s = prc_r + PR_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                // Lock success is tested first so it wins on the timeout cycle.
                if (lk_s && (stb_r == ST_W'(LOCK_STABLE_CYCLES - 1))) begin
                    state_nxt_s     = ST_RELEASE;
                    rst_out_n_nxt_s = STAGE0;
                    gap_nxt_s       = '0;
                end else if (tmo_r == TO_W'(LOCK_TIMEOUT - 1)) begin
                    state_nxt_s   = ST_PLLRST;
                    pll_rst_nxt_s = 1'b1;
                    // The entry edge already drives pll_rst high, so it counts
                    // as the first pulse cycle; after rst_n the count starts at 0
                    // because the reset cycle itself is not part of the pulse.
                    prc_nxt_s     = PR_W'(1);
                end else begin
                    stb_nxt_s = lk_s ? (stb_r + ST_W'(1)) : '0;
                    tmo_nxt_s = tmo_r + TO_W'(1);
                end
            end
            ST_RELEASE: begin
                if (!lk_s) begin
                    loss_evt_s = 1'b1;
                end else if (gap_r == GP_W'(STAGE_GAP - 1)) begin
                    gap_nxt_s = '0;
                    if (rst_out_n_r[NUM_STAGES-1]) begin
                        state_nxt_s = ST_RUN;
                        ready_nxt_s = 1'b1;
                    end else begin
                        rst_out_n_nxt_s = (rst_out_n_r << 1'b1) | STAGE0;
                    end
                end else begin
                    gap_nxt_s = gap_r + GP_W'(1);
                end
            end
            ST_RUN: begin
                if (!lk_s) begin
                    loss_evt_s = 1'b1;
                end else begin
                    ready_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s     = ST_PLLRST;
                pll_rst_nxt_s   = 1'b1;
                prc_nxt_s       = PR_W'(1);
                rst_out_n_nxt_s = '0;
                ready_nxt_s     = 1'b0;
            end
        endcase

        // Lock loss overrides whatever the stage logic chose above.
        if (loss_evt_s) begin
            state_nxt_s     = ST_WAIT_LOCK;
            rst_out_n_nxt_s = '0;
            ready_nxt_s     = 1'b0;
            stb_nxt_s       = '0;
            tmo_nxt_s       = '0;
            gap_nxt_s       = '0;
        end else begin
            gap_nxt_s = gap_nxt_s;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_PLLRST;
            prc_r       <= '0;
            stb_r       <= '0;
            tmo_r       <= '0;
            gap_r       <= '0;
            pll_rst_r   <= 1'b1;
            rst_out_n_r <= '0;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            prc_r       <= prc_nxt_s;
            stb_r       <= stb_nxt_s;
            tmo_r       <= tmo_nxt_s;
            gap_r       <= gap_nxt_s;
            pll_rst_r   <= pll_rst_nxt_s;
            rst_out_n_r <= rst_out_n_nxt_s;
            ready_r     <= ready_nxt_s;
        end
    end

    assign pll_rst   = pll_rst_r;
    assign rst_out_n = rst_out_n_r;
    assign ready     = ready_r;

`ifdef LOCK_LOSS_CNT_EN
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

    // Saturating loss counter; a clear coinciding with a loss leaves 1.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr_cnt) begin
            cnt_nxt_s = loss_evt_s ? CNT_W'(1) : '0;
        end else if (loss_evt_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Loss counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign lock_loss_cnt = cnt_r;
`else
    logic unused_s;
    assign unused_s      = &{1'b0, clr_cnt, loss_evt_s};
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
`timescale 1ns/1ps
// Directed bench for pll_lock_rst_seq: expectations are queued with the cycle
// they are due at and checked when the run reaches that cycle.
module tb_pll_lock_rst_seq;

    localparam int NS   = 3;
    localparam int CW   = 2;
    localparam int SPLL = 0;
    localparam int SRST = 1;
    localparam int SRDY = 2;
    localparam int SCNT = 3;

    logic          clk;
    logic          rst_n;
    logic          pll_locked;
    logic          clr_cnt;
    logic          pll_rst;
    logic [NS-1:0] rst_out_n;
    logic          ready;
    logic [CW-1:0] lock_loss_cnt;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   cyc;
    int   checks;
    int   errors;

    pll_lock_rst_seq #(
        .PLL_RST_CYCLES    (8),
        .LOCK_STABLE_CYCLES(16),
        .LOCK_TIMEOUT      (64),
        .STAGE_GAP         (4),
        .NUM_STAGES        (NS),
        .CNT_W             (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .clr_cnt      (clr_cnt),
        .pll_rst      (pll_rst),
        .rst_out_n    (rst_out_n),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int ce(int v);
`ifdef LOCK_LOSS_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic [31:0] obs_of(int s);
        case (s)
            SPLL:    return {31'b0, pll_rst};
            SRST:    return {29'b0, rst_out_n};
            SRDY:    return {31'b0, ready};
            default: return {30'b0, lock_loss_cnt};
        endcase
    endfunction

    task automatic push(int c, int s, int v, string t);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        e.tag = t;
        sb_q.push_back(e);
    endtask

    task automatic step(int n);
        logic [31:0] o;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc <= cyc) begin
                    o = obs_of(sb_q[i].sig);
                    checks++;
                    assert ((sb_q[i].cyc == cyc) && (o === sb_q[i].val)) else begin
                        errors++;
                        $error("FAIL %s cyc=%0d due=%0d got=%0h want=%0h",
                               sb_q[i].tag, cyc, sb_q[i].cyc, o, sb_q[i].val);
                    end
                    sb_q.delete(i);
                end
            end
        end
    endtask

    // Drop lock for 'low' cycles (optionally clearing the counter on the loss
    // edge), then re-lock and run 'tail' cycles; release is due 18 cycles
    // after re-assertion and pll_rst must stay low throughout.
    task automatic do_loss(int low, bit clr, int exp_cnt, int tail);
        int t;
        int l;
        t = cyc;
        l = t + low;
        push(t + 3, SRST, 0, "loss_rst");
        push(t + 3, SRDY, 0, "loss_rdy");
        push(t + 3, SCNT, ce(exp_cnt), "loss_cnt");
        for (int c = t + 1; c <= l + 18; c++) push(c, SPLL, 0, "no_repulse");
        push(l + 17, SRST, 0, "relock_hold");
        push(l + 18, SRST, 1, "relock_rel0");
        pll_locked = 1'b0;
        step(2);
        if (clr) clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        step(low - 3);
        pll_locked = 1'b1;
        step(tail);
    endtask

    initial begin
        int t;
        int l1;
        int l2;
        int w;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        clr_cnt    = 1'b0;

        // Reset state
        push(2, SPLL, 1, "rst_pll");
        push(2, SRST, 0, "rst_out");
        push(2, SRDY, 0, "rst_rdy");
        push(2, SCNT, 0, "rst_cnt");
        step(2);

        // Normal bring-up; cycle 1 is the first edge with rst_n high
        cyc   = 0;
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) push(c, SPLL, 1, "pr_hi");
        push(9, SPLL, 0, "pr_lo");
        push(37, SRST, 0, "up_hold");
        push(38, SRST, 1, "up_s0");
        push(41, SRST, 1, "up_s0_gap");
        push(42, SRST, 3, "up_s1");
        push(45, SRST, 3, "up_s1_gap");
        push(46, SRST, 7, "up_s2");
        push(49, SRDY, 0, "up_rdy_lo");
        push(50, SRDY, 1, "up_rdy");
        push(50, SRST, 7, "up_run");
        step(20);
        pll_locked = 1'b1;
        step(35);

        // Lock loss in RUN for 5 cycles, full re-sequence without pll_rst
        t  = cyc;
        l1 = t + 5;
        push(t + 2, SRST, 7, "run_pre");
        push(l1 + 22, SRST, 3, "rs_s1");
        push(l1 + 26, SRST, 7, "rs_s2");
        push(l1 + 29, SRDY, 0, "rs_rdy_lo");
        push(l1 + 30, SRDY, 1, "rs_rdy");
        do_loss(5, 1'b0, 1, 31);

        // Glitch during WAIT_LOCK after 10 stable cycles restarts the count
        t = cyc;
        push(t + 3, SRST, 0, "gl_loss");
        push(t + 3, SCNT, ce(2), "gl_cnt");
        pll_locked = 1'b0;
        step(4);
        pll_locked = 1'b1;
        l1 = cyc;
        push(l1 + 18, SRST, 0, "gl_norel");
        step(10);
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
        l2 = cyc;
        push(l2 + 17, SRST, 0, "gl_hold");
        push(l2 + 18, SRST, 1, "gl_s0");
        push(l2 + 22, SRST, 3, "gl_s1");
        push(l2 + 26, SRST, 7, "gl_s2");
        push(l2 + 30, SRDY, 1, "gl_rdy");
        step(31);

        // Counter saturation (CNT_W=2), plain clear, clear coinciding with loss
        do_loss(4, 1'b0, 3, 19);
        do_loss(4, 1'b0, 3, 19);
        do_loss(4, 1'b0, 3, 19);
        push(cyc + 1, SCNT, ce(0), "clr");
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
        do_loss(4, 1'b1, 1, 19);

        // Timeout: lock held low, pll_rst re-pulses 8 cycles every 72
        t = cyc;
        w = t + 3;
        push(w, SRST, 0, "to_loss");
        push(w, SCNT, ce(2), "to_cnt");
        push(w + 63, SPLL, 0, "to_pre");
        push(w + 64, SPLL, 1, "to_p1_hi");
        push(w + 71, SPLL, 1, "to_p1_end");
        push(w + 72, SPLL, 0, "to_p1_lo");
        push(w + 100, SRST, 0, "to_rst");
        push(w + 135, SPLL, 0, "to_pre2");
        push(w + 136, SPLL, 1, "to_p2_hi");
        push(w + 143, SPLL, 1, "to_p2_end");
        push(w + 144, SPLL, 0, "to_p2_lo");
        push(w + 144, SRST, 0, "to_rst2");
        pll_locked = 1'b0;
        step(w + 144 - cyc);

        // Reset while rst_out_n = 011
        l1 = cyc;
        pll_locked = 1'b1;
        push(l1 + 18, SRST, 1, "mr_s0");
        push(l1 + 22, SRST, 3, "mr_s1");
        push(l1 + 23, SRST, 0, "mr_rst");
        push(l1 + 23, SPLL, 1, "mr_pll");
        push(l1 + 23, SRDY, 0, "mr_rdy");
        push(l1 + 23, SCNT, 0, "mr_cnt");
        step(22);
        rst_n = 1'b0;
        step(1);
        push(cyc + 1, SPLL, 1, "mr_hold");
        step(1);
        rst_n = 1'b1;
        t = cyc;
        push(t + 8, SPLL, 1, "mr_pr_hi");
        push(t + 9, SPLL, 0, "mr_pr_lo");
        push(t + 24, SRST, 0, "mr_up_hold");
        push(t + 25, SRST, 1, "mr_up_s0");
        step(26);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain got=%0d want=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
